// File: rtl/fetch_sequencer_if.sv
// Issue-stage and ROM-side signals of the fetch sequencer, bundled for port hookup.
// The sequencer drives the master modport; the ROM/issue side uses the slave modport.
interface fetch_sequencer_if #(
  parameter int PC_W = 15
);
  logic            stall;
  logic [1:0]      issue_cnt;
  logic            br_valid;
  logic [PC_W-1:0] br_target;
  logic [15:0]     ir_0;
  logic [15:0]     ir_1;
  logic [PC_W-2:0] rom_addr;
  logic            pc_1;
  logic            sel_mem_1;
  logic [1:0]      sel_mem_0;
  logic [1:0]      inst_valid;
  logic [PC_W-1:0] pc_out;

  modport master (
    input  stall, issue_cnt, br_valid, br_target, ir_0, ir_1,
    output rom_addr, pc_1, sel_mem_1, sel_mem_0, inst_valid, pc_out
  );

  modport slave (
    output stall, issue_cnt, br_valid, br_target, ir_0, ir_1,
    input  rom_addr, pc_1, sel_mem_1, sel_mem_0, inst_valid, pc_out
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Dual-bank ROM fetch sequencer: up to two in-order instructions per cycle, branch redirect, halt.
// Zero-cycle fetch latency (combinational ROM); stall freezes the PC, branches insert one bubble.
module fetch_sequencer #(
  parameter int          PC_W        = 15,
  parameter logic [15:0] HALT_OPCODE = 16'h0000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  fetch_sequencer_if.master bus,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_BUBBLE,
    S_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [1:0]      n_vld;
  logic [1:0]      issue_clamp;
  logic [1:0]      acc;
  logic [CNT_W:0]  retired_sum;
  logic            cycle_tick;

  // Number of slots ahead of the first halt marker.
  always_comb begin
    n_vld = 2'd2;
    if (bus.ir_0 == HALT_OPCODE) begin
      n_vld = 2'd0;
    end else if (bus.ir_1 == HALT_OPCODE) begin
      n_vld = 2'd1;
    end
  end

  assign issue_clamp = (bus.issue_cnt == 2'd3) ? 2'd2 : bus.issue_cnt;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    acc            = 2'd0;
    bus.inst_valid = 2'b00;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        case (n_vld)
          2'd0:    bus.inst_valid = 2'b00;
          2'd1:    bus.inst_valid = 2'b01;
          default: bus.inst_valid = 2'b11;
        endcase
        if (bus.br_valid) begin
          pc_nxt    = bus.br_target;
          state_nxt = S_BUBBLE;
        end else if (n_vld == 2'd0) begin
          state_nxt = S_HALT;
        end else if (!bus.stall) begin
          acc    = (issue_clamp < n_vld) ? issue_clamp : n_vld;
          pc_nxt = pc + PC_W'(acc);
        end
      end
      S_BUBBLE: begin
        if (bus.br_valid) begin
          pc_nxt = bus.br_target;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_HALT;
      end
    endcase
  end

  assign retired_sum = {1'b0, retired} + (CNT_W+1)'(acc);
  assign cycle_tick  = (state == S_FETCH) || (state == S_BUBBLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      retired <= '0;
      cycles  <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      retired <= retired_sum[CNT_W] ? {CNT_W{1'b1}} : retired_sum[CNT_W-1:0];
      if (cycle_tick && (cycles != {CNT_W{1'b1}})) begin
        cycles <= cycles + 1'b1;
      end
    end
  end

  // Odd PC: slot 0 comes from bank1, slot 1 from bank0 (which reads row+1).
  assign bus.rom_addr  = pc[PC_W-1:1];
  assign bus.pc_1      = pc[0];
  assign bus.sel_mem_1 = ~pc[0];
  assign bus.sel_mem_0 = pc[0] ? 2'd2 : 2'd0;
  assign bus.pc_out    = pc;
  assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a dual-bank ROM model built from the mux outputs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic [31:0] retired;
  logic [31:0] cycles;

  int total = 0;
  int bad   = 0;
  int exp_retired = 0;
  int exp_cycles  = 0;

  typedef struct {
    logic [14:0] pc;
    logic [13:0] rom;
    logic [1:0]  vld;
  } exp_t;
  exp_t sb[$];

  // ROM contents: halfword h holds {1, h}; halt_a (when enabled) holds the halt opcode.
  logic        halt_en = 1'b0;
  logic [14:0] halt_a  = '0;
  logic [13:0] row0;
  logic [14:0] h_b0, h_b1;
  logic [15:0] b0, b1;

  fetch_sequencer_if #(.PC_W(15)) bus ();

  fetch_sequencer #(.PC_W(15), .HALT_OPCODE(16'h0000), .CNT_W(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .halted  (halted),
    .retired (retired),
    .cycles  (cycles)
  );

  always #5 clk = ~clk;

  assign row0     = bus.rom_addr + 14'(bus.pc_1);
  assign h_b0     = {row0, 1'b0};
  assign h_b1     = {bus.rom_addr, 1'b1};
  assign b0       = (halt_en && h_b0 == halt_a) ? 16'h0000 : {1'b1, h_b0};
  assign b1       = (halt_en && h_b1 == halt_a) ? 16'h0000 : {1'b1, h_b1};
  assign bus.ir_0 = (bus.sel_mem_0 == 2'd2) ? b1 : b0;
  assign bus.ir_1 = bus.sel_mem_1 ? b1 : b0;

  // Advance one clock; counted marks a cycle the DUT spends in FETCH or BUBBLE.
  task automatic step(input bit counted, input int acc);
    @(posedge clk);
    #1;
    exp_cycles  += int'(counted);
    exp_retired += acc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    bus.stall = 1'b0; bus.issue_cnt = 2'd0; bus.br_valid = 1'b0; bus.br_target = '0;
    #12;
    total++;
    if ({bus.inst_valid, halted, bus.pc_out} !== {2'b00, 1'b0, 15'h0}) begin
      bad++; $display("FAIL reset_state act=%b/%b/%h exp=00/0/0000", bus.inst_valid, halted, bus.pc_out);
    end
    total++;
    if ({bus.rom_addr, bus.pc_1, bus.sel_mem_0, bus.sel_mem_1} !== {14'h0, 1'b0, 2'd0, 1'b1}) begin
      bad++; $display("FAIL reset_mux act=%h/%b/%0d/%b exp=0/0/0/1", bus.rom_addr, bus.pc_1, bus.sel_mem_0, bus.sel_mem_1);
    end
    total++;
    if (retired !== 32'd0 || cycles !== 32'd0) begin
      bad++; $display("FAIL reset_counters act=%0d/%0d exp=0/0", retired, cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0);
  endtask

  task automatic test_stream();
    exp_t e;
    start = 1'b1; bus.issue_cnt = 2'd2;
    step(0, 0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back('{pc: 15'(2*i), rom: 14'(i), vld: 2'b11});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (bus.pc_out !== e.pc || bus.rom_addr !== e.rom || bus.inst_valid !== e.vld ||
          bus.sel_mem_0 !== 2'd0 || bus.sel_mem_1 !== 1'b1 || bus.pc_1 !== 1'b0) begin
        bad++; $display("FAIL stream_%0d act=pc%h row%h v%b s0=%0d s1=%b p1=%b exp=pc%h row%h v%b 0/1/0",
                        i, bus.pc_out, bus.rom_addr, bus.inst_valid, bus.sel_mem_0, bus.sel_mem_1, bus.pc_1, e.pc, e.rom, e.vld);
      end
      step(1, 2);
    end
    total++;
    if (retired !== 32'd8 || cycles !== 32'd4) begin
      bad++; $display("FAIL stream_counters act=%0d/%0d exp=8/4", retired, cycles);
    end
  endtask

  task automatic redirect(input logic [14:0] tgt);
    bus.issue_cnt = 2'd0; bus.br_valid = 1'b1; bus.br_target = tgt;
    step(1, 0);
    bus.br_valid = 1'b0;
    step(1, 0);
  endtask

  task automatic test_odd_pc();
    exp_t e;
    redirect(15'h0);
    bus.issue_cnt = 2'd1;
    step(1, 1);
    sb.push_back('{pc: 15'h1, rom: 14'h0, vld: 2'b11});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (bus.pc_out !== e.pc || bus.rom_addr !== e.rom || bus.inst_valid !== e.vld ||
        bus.pc_1 !== 1'b1 || bus.sel_mem_0 !== 2'd2 || bus.sel_mem_1 !== 1'b0) begin
      bad++; $display("FAIL odd_pc act=pc%h row%h v%b p1=%b s0=%0d s1=%b exp=pc1 row0 v11 1/2/0",
                      bus.pc_out, bus.rom_addr, bus.inst_valid, bus.pc_1, bus.sel_mem_0, bus.sel_mem_1);
    end
    bus.issue_cnt = 2'd2;
    step(1, 2);
    sb.push_back('{pc: 15'h3, rom: 14'h1, vld: 2'b11});
    bus.issue_cnt = 2'd3;
    step(1, 2);
    sb.push_back('{pc: 15'h5, rom: 14'h2, vld: 2'b11});
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      total++;
      if (i == 0 && bus.pc_out !== 15'h5) begin
        bad++; $display("FAIL issue3_clamp act=%h exp=%h", bus.pc_out, 15'h5);
      end else if (i == 1 && (bus.pc_out !== e.pc || bus.rom_addr !== e.rom)) begin
        bad++; $display("FAIL odd_pc_next act=pc%h row%h exp=pc%h row%h", bus.pc_out, bus.rom_addr, e.pc, e.rom);
      end
    end
  endtask

  task automatic test_stall_branch();
    redirect(15'h4);
    bus.stall = 1'b1; bus.issue_cnt = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      total++;
      if (bus.pc_out !== 15'h4 || bus.inst_valid !== 2'b11) begin
        bad++; $display("FAIL stall_hold_%0d act=pc%h v%b exp=pc0004 v11", i, bus.pc_out, bus.inst_valid);
      end
    end
    total++;
    if (retired !== 32'(exp_retired) || cycles !== 32'(exp_cycles)) begin
      bad++; $display("FAIL stall_counters act=%0d/%0d exp=%0d/%0d", retired, cycles, exp_retired, exp_cycles);
    end
    bus.br_valid = 1'b1; bus.br_target = 15'h5;
    step(1, 0);
    bus.br_valid = 1'b0; bus.stall = 1'b0; bus.issue_cnt = 2'd0;
    total++;
    if (bus.inst_valid !== 2'b00 || bus.pc_out !== 15'h5) begin
      bad++; $display("FAIL branch_bubble act=v%b pc%h exp=v00 pc0005", bus.inst_valid, bus.pc_out);
    end
    step(1, 0);
    total++;
    if (bus.sel_mem_0 !== 2'd2 || bus.inst_valid !== 2'b11) begin
      bad++; $display("FAIL branch_resume act=s0=%0d v%b exp=s0=2 v11", bus.sel_mem_0, bus.inst_valid);
    end
    // Re-target while already in the bubble.
    bus.br_valid = 1'b1; bus.br_target = 15'h6;
    step(1, 0);
    bus.br_target = 15'h7;
    step(1, 0);
    bus.br_valid = 1'b0;
    total++;
    if (bus.inst_valid !== 2'b00 || bus.pc_out !== 15'h7) begin
      bad++; $display("FAIL bubble_retarget act=v%b pc%h exp=v00 pc0007", bus.inst_valid, bus.pc_out);
    end
    step(1, 0);
  endtask

  task automatic test_halt();
    halt_en = 1'b1; halt_a = 15'h8;
    #1;
    total++;
    if (bus.inst_valid !== 2'b01) begin
      bad++; $display("FAIL halt_slot1 act=%b exp=01", bus.inst_valid);
    end
    bus.issue_cnt = 2'd2;
    step(1, 1);
    total++;
    if (bus.pc_out !== 15'h8 || retired !== 32'(exp_retired) || bus.inst_valid !== 2'b00) begin
      bad++; $display("FAIL halt_partial act=pc%h r%0d v%b exp=pc0008 r%0d v00", bus.pc_out, retired, bus.inst_valid, exp_retired);
    end
    step(1, 0);
    start = 1'b1; bus.br_valid = 1'b1; bus.br_target = 15'h20;
    step(0, 0);
    step(0, 0);
    total++;
    if (halted !== 1'b1 || bus.pc_out !== 15'h8 || bus.inst_valid !== 2'b00 || cycles !== 32'(exp_cycles)) begin
      bad++; $display("FAIL halt_sticky act=h%b pc%h v%b c%0d exp=h1 pc0008 v00 c%0d", halted, bus.pc_out, bus.inst_valid, cycles, exp_cycles);
    end
    start = 1'b0; bus.br_valid = 1'b0; bus.issue_cnt = 2'd0; halt_en = 1'b0;
  endtask

  task automatic test_wrap_reset();
    exp_t e;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_retired = 0; exp_cycles = 0;
    start = 1'b1;
    step(0, 0);
    start = 1'b0;
    redirect(15'h7FFF);
    total++;
    if (bus.pc_out !== 15'h7FFF || bus.rom_addr !== 14'h3FFF || bus.pc_1 !== 1'b1 || bus.inst_valid !== 2'b11) begin
      bad++; $display("FAIL top_row act=pc%h row%h p1=%b v%b exp=pc7fff row3fff p1=1 v11", bus.pc_out, bus.rom_addr, bus.pc_1, bus.inst_valid);
    end
    bus.issue_cnt = 2'd2;
    step(1, 2);
    sb.push_back('{pc: 15'h1, rom: 14'h0, vld: 2'b11});
    e = sb.pop_front();
    total++;
    if (bus.pc_out !== e.pc || bus.rom_addr !== e.rom || retired !== 32'(exp_retired)) begin
      bad++; $display("FAIL pc_wrap act=pc%h row%h r%0d exp=pc%h row%h r%0d", bus.pc_out, bus.rom_addr, retired, e.pc, e.rom, exp_retired);
    end
    bus.br_valid = 1'b1; bus.br_target = 15'h40;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.inst_valid, halted, bus.pc_out, bus.sel_mem_0, bus.sel_mem_1} !== {2'b00, 1'b0, 15'h0, 2'd0, 1'b1} ||
        retired !== 32'd0 || cycles !== 32'd0) begin
      bad++; $display("FAIL midrun_reset act=v%b h%b pc%h s0=%0d s1=%b r%0d c%0d exp=v00 h0 pc0 s0=0 s1=1 r0 c0",
                      bus.inst_valid, halted, bus.pc_out, bus.sel_mem_0, bus.sel_mem_1, retired, cycles);
    end
    bus.br_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_odd_pc();
    test_stall_branch();
    test_halt();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
